// File: rtl/mem_stage.sv
// Memory-access stage: turns ALU results into writebacks or single-outstanding
// data-bus transactions, then aligns and extends load data for the register file.
// Optional bus watchdog: define MEM_STAGE_TIMEOUT_EN to add a 10-bit BUS timeout
// and the bus_timeout pulse output.
module mem_stage #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned BUS_BYTES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_load,
  input  logic                 in_store,
  input  logic [2:0]           in_funct3,
  input  logic [XLEN-1:0]      in_data,
  input  logic [XLEN-1:0]      in_addr,
  input  logic [4:0]           in_rd,
  input  logic                 is_flush,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [BUS_BYTES-1:0] mem_wstrb,
  input  logic                 mem_ack,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 wb_valid,
  output logic [4:0]           wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 misaligned
`ifdef MEM_STAGE_TIMEOUT_EN
  ,
  output logic                 bus_timeout
`endif
);

  typedef enum logic [1:0] {StIdle, StBus, StWb} state_e;

  state_e                 state;
  logic                   wb_pulse;
  logic                   load_q;
  logic                   cancel_q;
  logic [2:0]             funct3_q;
  logic [2:0]             off_q;
  logic [4:0]             rd_q;
`ifdef MEM_STAGE_TIMEOUT_EN
  logic [9:0]             tmo_cnt;
`endif

  logic                   accept;
  logic [XLEN-1:0]        eff_addr;
  logic [2:0]             off;
  logic                   aligned;
  logic [BUS_BYTES-1:0]   size_mask;
  logic [XLEN-1:0]        shifted;
  logic [XLEN-1:0]        load_ext;

  assign in_ready = (state == StIdle) && !reset;
  assign accept   = in_valid && in_ready && !is_flush;
  // A flush during the WB cycle kills the load writeback already staged there.
  assign wb_valid = wb_pulse && !((state == StWb) && is_flush);

  // Decode effective address, byte offset, natural alignment and size mask.
  always_comb begin
    eff_addr  = in_load ? in_data : in_addr;
    off       = eff_addr[2:0];
    aligned   = 1'b1;
    size_mask = BUS_BYTES'(8'hFF);
    case (in_funct3[1:0])
      2'd0: size_mask = BUS_BYTES'(8'h01);
      2'd1: begin
        size_mask = BUS_BYTES'(8'h03);
        aligned   = (off[0] == 1'b0);
      end
      2'd2: begin
        size_mask = BUS_BYTES'(8'h0F);
        aligned   = (off[1:0] == 2'b00);
      end
      default: begin
        size_mask = BUS_BYTES'(8'hFF);
        aligned   = (off == 3'b000);
      end
    endcase
  end

  // Move the addressed lane down to bit 0 and sign/zero-extend by access size.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'd0:    load_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'd1:    load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'd2:    load_ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'd4:    load_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'd5:    load_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      3'd6:    load_ext = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  // Stage FSM with registered bus, writeback and misalignment outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      wb_pulse   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      misaligned <= 1'b0;
      load_q     <= 1'b0;
      cancel_q   <= 1'b0;
      funct3_q   <= '0;
      off_q      <= '0;
      rd_q       <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
      tmo_cnt     <= '0;
      bus_timeout <= 1'b0;
`endif
    end else begin
      wb_pulse   <= 1'b0;
      misaligned <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
      bus_timeout <= 1'b0;
`endif
      case (state)
        StIdle: begin
          if (accept) begin
            if (!in_load && !in_store) begin
              wb_pulse <= 1'b1;
              wb_rd    <= in_rd;
              wb_data  <= (in_rd == 5'd0) ? '0 : in_data;
            end else if (!aligned) begin
              misaligned <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= in_store;
              mem_addr  <= {eff_addr[XLEN-1:3], 3'b000};
              mem_wdata <= in_data << {off, 3'b000};
              mem_wstrb <= size_mask << off;
              load_q    <= in_load;
              cancel_q  <= 1'b0;
              funct3_q  <= in_funct3;
              off_q     <= off;
              rd_q      <= in_rd;
`ifdef MEM_STAGE_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
              state     <= StBus;
            end
          end
        end
        StBus: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            // Flush on the ack cycle itself still cancels the load writeback.
            if (load_q && !cancel_q && !is_flush) begin
              state    <= StWb;
              wb_pulse <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= (rd_q == 5'd0) ? '0 : load_ext;
            end else begin
              state <= StIdle;
            end
          end else begin
            if (is_flush) begin
              cancel_q <= 1'b1;
            end
`ifdef MEM_STAGE_TIMEOUT_EN
            if (tmo_cnt == 10'd1023) begin
              mem_req     <= 1'b0;
              bus_timeout <= 1'b1;
              state       <= StIdle;
            end else begin
              tmo_cnt <= tmo_cnt + 10'd1;
            end
`endif
          end
        end
        StWb: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases from the stage's intended
// behaviour plus randomized instruction streams against a transaction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_load, in_store, is_flush;
  logic [2:0]  in_funct3;
  logic [63:0] in_data, in_addr;
  logic [4:0]  in_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        misaligned;
`ifdef MEM_STAGE_TIMEOUT_EN
  logic        bus_timeout;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // Expected outputs for the current cycle, set by the stimulus process.
  bit          chk_en = 0;
  bit          e_ready, e_req, e_we, e_wb, e_mis;
  logic [63:0] e_addr, e_wdata, e_wbd;
  logic [7:0]  e_wstrb;
  logic [4:0]  e_rd;
  // Results due one cycle after an IDLE beat.
  bit          p_wb, p_mis;
  logic [4:0]  p_rd;
  logic [63:0] p_wbd;

  // Observations used by the directed literal checks.
  int          wb_seen = 0;
  int          mis_seen = 0;
  logic [63:0] last_wbd, last_addr, last_wdata;
  logic [4:0]  last_rd;
  logic [7:0]  last_wstrb;
  logic        last_we;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(64), .BUS_BYTES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_load    (in_load),
    .in_store   (in_store),
    .in_funct3  (in_funct3),
    .in_data    (in_data),
    .in_addr    (in_addr),
    .in_rd      (in_rd),
    .is_flush   (is_flush),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .misaligned (misaligned)
`ifdef MEM_STAGE_TIMEOUT_EN
    ,
    .bus_timeout(bus_timeout)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: access size in bytes, byte mask, and loaded value.
  function automatic int ref_bytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      default:    return 8;
    endcase
  endfunction

  function automatic logic [7:0] ref_mask(input logic [2:0] f3, input logic [2:0] off);
    int m;
    m = ((1 << ref_bytes(f3)) - 1) << off;
    return m[7:0];
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] off,
                                           input logic [63:0] rdata);
    int          n;
    logic [63:0] v, m;
    n = ref_bytes(f3);
    v = rdata >> (8 * off);
    if (n == 8) return v;
    m = (64'd1 << (8 * n)) - 64'd1;
    v = v & m;
    if (f3 < 3'd4 && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  // Single compare process: every cycle, DUT outputs against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, e_ready);
      chk("mem_req", mem_req, e_req);
      if (e_req && mem_req) begin
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_wstrb", mem_wstrb, e_wstrb);
        last_addr = mem_addr; last_wdata = mem_wdata;
        last_wstrb = mem_wstrb; last_we = mem_we;
      end
      chk("wb_valid", wb_valid, e_wb);
      if (e_wb && wb_valid) begin
        chk("wb_rd", wb_rd, e_rd);
        chk("wb_data", wb_data, e_wbd);
      end
      chk("misaligned", misaligned, e_mis);
    end
    if (wb_valid) begin
      wb_seen++;
      last_wbd = wb_data;
      last_rd  = wb_rd;
    end
    if (misaligned) mis_seen++;
  end

  // Advance one cycle: apply due results, default idle inputs with random noise.
  task automatic step();
    @(posedge clk);
    #1;
    e_wb  = p_wb;  e_rd = p_rd; e_wbd = p_wbd; e_mis = p_mis;
    p_wb  = 0;     p_mis = 0;
    e_ready = 1;   e_req = 0;
    in_valid  = 0;
    is_flush  = 0;
    in_load   = 1'($urandom);
    in_store  = 1'($urandom);
    in_funct3 = 3'($urandom);
    in_data   = {$urandom, $urandom};
    in_addr   = {$urandom, $urandom};
    in_rd     = 5'($urandom);
    mem_ack   = ($urandom % 4 == 0);  // stray acks while idle must be ignored
    mem_rdata = {$urandom, $urandom};
  endtask

  // One instruction from its beat to its final writeback.
  task automatic do_instr(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [63:0] data, input logic [63:0] addr,
                          input logic [4:0] rd, input bit fl, input int dly,
                          input logic [63:0] rdata, input int flush_bus, input bit flush_wb);
    logic [63:0] a;
    logic [2:0]  off;
    bit          cancel;
    step();
    in_valid = 1; in_load = ld; in_store = st; in_funct3 = f3;
    in_data = data; in_addr = addr; in_rd = rd; is_flush = fl;
    if (fl) return;
    if (!ld && !st) begin
      p_wb = 1; p_rd = rd; p_wbd = (rd == 0) ? 64'd0 : data;
      return;
    end
    a   = ld ? data : addr;
    off = a[2:0];
    if ((off % ref_bytes(f3)) != 0) begin
      p_mis = 1;
      return;
    end
    cancel = 0;
    for (int i = 0; i <= dly; i++) begin
      step();
      e_ready = 0; e_req = 1; e_we = st;
      e_addr  = {a[63:3], 3'b000};
      e_wdata = data << (8 * off);
      e_wstrb = ref_mask(f3, off);
      in_valid = 1'($urandom);  // must not be taken while busy
      mem_ack  = (i == dly);
      if (i == dly) mem_rdata = rdata;
      is_flush = (i == flush_bus);
      cancel   = cancel | is_flush;
    end
    if (ld && !cancel) begin
      step();
      e_ready  = 0;
      in_valid = 1'($urandom);
      is_flush = flush_wb;
      if (!flush_wb) begin
        e_wb = 1; e_rd = rd; e_wbd = (rd == 0) ? 64'd0 : ref_load(f3, off, rdata);
      end
    end
  endtask

  task automatic settle();
    step();
    @(negedge clk);
    #1;
  endtask

  int          wb0, mis0;
  logic [63:0] ra;
  int          kind, dly, fb;
  bit          ld, st;
  logic [2:0]  f3;
  logic [4:0]  rd;

  initial begin
    reset = 1;
    in_valid = 0; in_load = 0; in_store = 0; in_funct3 = 0;
    in_data = 0; in_addr = 0; in_rd = 0; is_flush = 0;
    mem_ack = 0; mem_rdata = 0;
    p_wb = 0; p_mis = 0; p_rd = 0; p_wbd = 0;
    e_ready = 1; e_req = 0; e_wb = 0; e_mis = 0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_misaligned", misaligned, 0);
    @(posedge clk); #1;
    reset = 0;
    #1;
    chk("ready_after_rst", in_ready, 1);
    chk_en = 1;

    // ALU pass-through.
    wb0 = wb_seen;
    do_instr(0, 0, 3'd3, 64'h1234, 64'd0, 5'd5, 0, 0, 64'd0, -1, 0);
    settle();
    chk("pass_wb_count", 64'(wb_seen - wb0), 1);
    chk("pass_wb_rd", last_rd, 5);
    chk("pass_wb_data", last_wbd, 64'h1234);

    // SB at 0x1003.
    wb0 = wb_seen;
    do_instr(0, 1, 3'd0, 64'hAB, 64'h1003, 5'd7, 0, 2, 64'd0, -1, 0);
    settle();
    chk("sb_addr", last_addr, 64'h1000);
    chk("sb_wstrb", last_wstrb, 8'h08);
    chk("sb_wdata", last_wdata, 64'hAB00_0000);
    chk("sb_we", last_we, 1);
    chk("sb_no_wb", 64'(wb_seen - wb0), 0);

    // LB / LBU at 0x2005.
    do_instr(1, 0, 3'd0, 64'h2005, 64'd0, 5'd9, 0, 1, 64'h0000_8000_0000_0000, -1, 0);
    settle();
    chk("lb_data", last_wbd, 64'hFFFF_FFFF_FFFF_FF80);
    do_instr(1, 0, 3'd4, 64'h2005, 64'd0, 5'd9, 0, 0, 64'h0000_8000_0000_0000, -1, 0);
    settle();
    chk("lbu_data", last_wbd, 64'h80);

    // Misaligned LW.
    wb0 = wb_seen; mis0 = mis_seen;
    do_instr(1, 0, 3'd2, 64'h3002, 64'd0, 5'd4, 0, 0, 64'd0, -1, 0);
    settle();
    chk("lw_mis_count", 64'(mis_seen - mis0), 1);
    chk("lw_mis_no_wb", 64'(wb_seen - wb0), 0);

    // LD flushed while on the bus.
    wb0 = wb_seen;
    do_instr(1, 0, 3'd3, 64'h4000, 64'd0, 5'd6, 0, 2, 64'h1122_3344_5566_7788, 1, 0);
    settle();
    chk("ld_flush_no_wb", 64'(wb_seen - wb0), 0);

    // Reset in the middle of a bus transaction.
    step();
    in_valid = 1; in_load = 1; in_store = 0; in_funct3 = 3'd3;
    in_data = 64'h5000; in_rd = 5'd8; mem_ack = 0;
    @(posedge clk); #1;
    chk_en = 0;
    in_valid = 0; mem_ack = 0;
    @(negedge clk);
    chk("mid_req_up", mem_req, 1);
    #2;
    reset = 1;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 0;
    e_ready = 1; e_req = 0; e_wb = 0; e_mis = 0;
    @(negedge clk);
    chk_en = 1;
    wb0 = wb_seen;
    do_instr(0, 0, 3'd0, 64'hBEEF, 64'd0, 5'd3, 0, 0, 64'd0, -1, 0);
    settle();
    chk("post_rst_wb_count", 64'(wb_seen - wb0), 1);
    chk("post_rst_wb_data", last_wbd, 64'hBEEF);

    // Randomized instruction stream.
    for (int it = 0; it < 600; it++) begin
      kind = $urandom % 3;
      ld = (kind == 1);
      st = (kind == 2);
      f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      ra = {$urandom, $urandom};
      if ($urandom % 2 == 0) ra = ra & ~64'(ref_bytes(f3) - 1);
      rd  = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
      dly = $urandom_range(0, 3);
      fb  = ($urandom % 6 == 0) ? $urandom_range(0, dly) : -1;
      if (ld)
        do_instr(1, 0, f3, ra, {$urandom, $urandom}, rd, ($urandom % 8 == 0), dly,
                 {$urandom, $urandom}, fb, ($urandom % 6 == 0));
      else
        do_instr(0, st, f3, {$urandom, $urandom}, ra, rd, ($urandom % 8 == 0), dly,
                 {$urandom, $urandom}, fb, ($urandom % 6 == 0));
    end
    step();
    step();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute/ALU stage.
- Consumes ALU results: pass-through writeback values, load effective addresses, and store address/data pairs.
- Drives a single-outstanding 64-bit request/acknowledge data-memory bus, aligns and extends load data, and presents one writeback per instruction to the register file.
- Back-pressures the ALU via in_ready while a bus transaction is pending.

Parameters:
- XLEN, 64, datapath, address and register width.
- BUS_BYTES, 8, data bus width in bytes; mem_wstrb width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  ALU result valid this cycle
- in_ready  output  1  stage can accept an ALU result
- in_load  input  1  instruction is a load; in_data is the effective address
- in_store  input  1  instruction is a store; in_data is store data
- in_funct3  input  3  RISC-V size/sign: 0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU
- in_data  input  XLEN  ALU result / load address / store data
- in_addr  input  XLEN  store address (stores only)
- in_rd  input  5  destination register
- is_flush  input  1  squash younger instructions
- mem_req  output  1  bus request
- mem_we  output  1  1 = write
- mem_addr  output  XLEN  doubleword-aligned address
- mem_wdata  output  XLEN  lane-positioned store data
- mem_wstrb  output  BUS_BYTES  byte enables
- mem_ack  input  1  bus completion, single-cycle pulse
- mem_rdata  input  XLEN  read data, valid with mem_ack
- wb_valid  output  1  writeback valid (1-cycle pulse)
- wb_rd  output  5  writeback register
- wb_data  output  XLEN  writeback value
- misaligned  output  1  1-cycle pulse: access not naturally aligned

Behaviour:
- Reset (async): state IDLE; mem_req, mem_we, wb_valid and misaligned = 0; mem_addr, mem_wdata, mem_wstrb, wb_rd and wb_data = 0; in_ready = 1 once reset deasserts.
- States are IDLE, BUS and WB.
- in_ready = (state == IDLE) && !reset.
- A beat is accepted when in_valid && in_ready && !is_flush.
- Non-memory beat:
  - wb_valid=1, wb_rd=in_rd, wb_data=in_data on the next cycle (1-cycle latency).
  - State stays IDLE.
- Memory beat:
  - Let a = load ? in_data : in_addr, and off = a[2:0].
  - Aligned when (H: off[0]==0), (W: off[1:0]==0), (D: off==0).
  - Misaligned: misaligned pulses next cycle, no bus request, no writeback, state stays IDLE.
  - Aligned: capture request, go to BUS; mem_req=1 from the next cycle.
  - mem_addr = {a[XLEN-1:3], 3'b000}.
  - mem_wstrb = size mask << off, where size mask is B 0x01, H 0x03, W 0x0F, D 0xFF.
  - For loads, mem_wstrb is the same mask and mem_we=0.
  - mem_wdata = in_data << (8*off).
- BUS:
  - mem_req and all bus outputs are held stable until the mem_ack cycle. mem_ack is ignored when mem_req=0.
  - On mem_ack, mem_req drops the next cycle.
  - Store with ack: go to IDLE with no writeback.
  - Load with ack: go to WB. Register x = mem_rdata >> (8*off), then extend x by funct3: B/H/W sign-extend from bit 7/15/31; BU/HU/WU zero-extend; D takes x unchanged.
- WB: wb_valid=1 for one cycle with the extended data, then IDLE. Load-to-writeback latency is ack + 1 cycle.
- in_rd == 0: wb_valid is still pulsed, with wb_data forced to 0.
- Flush:
  - is_flush in IDLE: incoming beat is discarded.
  - is_flush in BUS: the bus transaction runs to ack (it cannot be aborted), and the pending load writeback is cancelled; a pending store still completes.
  - is_flush in WB: wb_valid is suppressed.
- mem_ack arriving in the same cycle as a new in_valid: in_valid is not accepted, because in_ready=0 in BUS.
- Reset mid-transaction: mem_req drops asynchronously and the bus transaction is abandoned. The bus side must tolerate this.

Optional Feature:
- Macro MEM_STAGE_TIMEOUT_EN.
- When defined:
  - A 10-bit counter clears on entry to BUS and increments every BUS cycle without ack.
  - At 1023 the stage drops mem_req and returns to IDLE. It pulses a bus_timeout output (1 bit, reset 0) for one cycle, with no writeback.
- When undefined: no counter and no bus_timeout port; BUS waits indefinitely.

Test Plan:
- ALU pass-through: in_data=0x1234, rd=5 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234; no mem_req.
- SB: in_addr=0x1003, in_data=0xAB -> mem_addr=0x1000, mem_wstrb=0x08, mem_wdata=0xAB000000, mem_we=1; ack after 3 cycles -> IDLE, no wb_valid.
- LB: addr=0x2005, funct3=0, mem_rdata=0x0000_8000_0000_0000 -> wb_data=0xFFFF_FFFF_FFFF_FF80. Same access with LBU (funct3=4) -> wb_data=0x80.
- LW at 0x3002 -> misaligned pulse, mem_req stays 0, no wb_valid.
- LD at 0x4000, is_flush during BUS -> mem_req held until ack, wb_valid never asserted, in_ready=1 the cycle after ack.
- Reset asserted while mem_req=1 -> mem_req=0 immediately; after release, a pass-through beat writes back normally.
